// File: rtl/btb_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_ctrl_pkg
//  Description : Shared BTB geometry, update-queue depth, FSM state encodings
//                and the PC-to-line-index select macro.
//  Revision    : 1.0 - initial release
// ============================================================================
package btb_update_ctrl_pkg;

    localparam int c_addr_width  = 32;
    localparam int c_btb_size    = 64;
    localparam int c_index_width = 6;
    localparam int c_queue_depth = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// Word-aligned PCs: the two LSBs never select a line.
`ifndef BTB_LINE_INDEX
`define BTB_LINE_INDEX(pc_sig, iw) pc_sig[(iw)+1:2]
`endif

`default_nettype wire

// File: rtl/btb_update_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_fifo
//  Description : Two-write / one-read update queue with occupancy and a
//                free-slot count that credits this cycle's pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_update_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int WIDTH = 66,
    parameter int DEPTH = c_queue_depth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push_a,
    input  logic [WIDTH-1:0]         data_a,
    input  logic                     push_b,
    input  logic [WIDTH-1:0]         data_b,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_wr_ptr_b;

    // push_b is only ever raised together with push_a, so it lands one slot later.
    assign w_wr_ptr_b = r_wr_ptr + c_ptr_w'(1);

    always_ff @(posedge clk) begin
        if (push_a) begin
            r_mem[r_wr_ptr] <= data_a;
        end
        if (push_b) begin
            r_mem[w_wr_ptr_b] <= data_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(push_a) + c_ptr_w'(push_b);
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(pop);
            r_count  <= r_count + c_cnt_w'(push_a) + c_cnt_w'(push_b) - c_cnt_w'(pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign free  = c_cnt_w'(DEPTH) - r_count + c_cnt_w'(pop);

endmodule

`default_nettype wire

// File: rtl/btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btb_update_ctrl
//  Description : Arbitrates ID and commit BTB updates through a small queue
//                onto the single BTB write port; sweeps the BTB on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_addr_width,
    parameter int BTB_SIZE    = c_btb_size,
    parameter int INDEX_WIDTH = c_index_width,
    parameter int QUEUE_DEPTH = c_queue_depth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_is_jump,
    input  logic [ADDR_WIDTH-1:0]  id_pc,
    input  logic [ADDR_WIDTH-1:0]  id_target,
    input  logic                   cmt_valid,
    output logic                   cmt_ready,
    input  logic                   cmt_invalidate,
    input  logic                   cmt_is_jump,
    input  logic [ADDR_WIDTH-1:0]  cmt_pc,
    input  logic [ADDR_WIDTH-1:0]  cmt_target,
    input  logic                   flush_req,
    output logic                   flush_busy,
    output logic                   btb_write_en,
    output logic [INDEX_WIDTH-1:0] btb_index,
    output logic                   btb_valid,
    output logic                   btb_is_jump,
    output logic [ADDR_WIDTH-1:0]  btb_pc,
    output logic [ADDR_WIDTH-1:0]  btb_target,
    output logic [15:0]            drop_count
);

    localparam int c_entry_w = 2 + 2 * ADDR_WIDTH;
    localparam int c_cnt_w   = $clog2(QUEUE_DEPTH) + 1;

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_sweep_idx;
    logic                   r_live;
    logic [15:0]            r_drop_count;

    logic [c_entry_w-1:0]   w_cmt_entry;
    logic [c_entry_w-1:0]   w_id_entry;
    logic [c_entry_w-1:0]   w_push_a_data;
    logic [c_entry_w-1:0]   w_head;
    logic [c_cnt_w-1:0]     w_count;
    logic [c_cnt_w-1:0]     w_free;
    logic [c_cnt_w-1:0]     w_count_next;
    logic                   w_open;
    logic                   w_deq;
    logic                   w_cmt_push;
    logic                   w_id_push;
    logic                   w_id_drop;
    logic                   w_push_a;
    logic                   w_push_b;
    logic                   w_head_valid;
    logic                   w_head_jump;
    logic [ADDR_WIDTH-1:0]  w_head_pc;
    logic [ADDR_WIDTH-1:0]  w_head_target;

    assign w_cmt_entry = {~cmt_invalidate, cmt_is_jump, cmt_pc, cmt_target};
    assign w_id_entry  = {1'b1, id_is_jump, id_pc, id_target};
    assign {w_head_valid, w_head_jump, w_head_pc, w_head_target} = w_head;

    // A flush request wins over everything in its own cycle: no write, no accept.
    assign w_deq      = (r_state == ST_DRAIN) && !flush_req;
    assign w_open     = r_live && (r_state != ST_FLUSH) && !flush_req;
    assign cmt_ready  = w_open && (w_free != '0);
    assign w_cmt_push = cmt_valid && cmt_ready;
    assign w_id_push  = id_valid && w_open && (w_free > c_cnt_w'(w_cmt_push));
    assign w_id_drop  = id_valid && (r_state != ST_FLUSH) && !flush_req && !w_id_push;

    // Commit takes the first slot; ID rides in the second when both fit.
    assign w_push_a      = w_cmt_push || w_id_push;
    assign w_push_b      = w_cmt_push && w_id_push;
    assign w_push_a_data = w_cmt_push ? w_cmt_entry : w_id_entry;
    assign w_count_next  = w_count + c_cnt_w'(w_push_a) + c_cnt_w'(w_push_b) - c_cnt_w'(w_deq);

    btb_update_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush_req),
        .push_a (w_push_a),
        .data_a (w_push_a_data),
        .push_b (w_push_b),
        .data_b (w_id_entry),
        .pop    (w_deq),
        .head   (w_head),
        .count  (w_count),
        .free   (w_free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_sweep_idx  <= '0;
            r_live       <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_id_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (flush_req) begin
                r_state     <= ST_FLUSH;
                r_sweep_idx <= '0;
            end else begin
                case (r_state)
                    ST_FLUSH: begin
                        if (r_sweep_idx == INDEX_WIDTH'(BTB_SIZE - 1)) begin
                            r_state     <= ST_IDLE;
                            r_sweep_idx <= '0;
                        end else begin
                            r_sweep_idx <= r_sweep_idx + INDEX_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_state <= (w_count_next != '0) ? ST_DRAIN : ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The write port is fed straight from state flops and the queue head, so
    // an entry enqueued this cycle is written in the next.
    always_comb begin
        btb_write_en = 1'b0;
        btb_index    = '0;
        btb_valid    = 1'b0;
        btb_is_jump  = 1'b0;
        btb_pc       = '0;
        btb_target   = '0;
        if (!flush_req) begin
            if (r_state == ST_DRAIN) begin
                btb_write_en = 1'b1;
                btb_index    = `BTB_LINE_INDEX(w_head_pc, INDEX_WIDTH);
                btb_valid    = w_head_valid;
                btb_is_jump  = w_head_jump;
                btb_pc       = w_head_pc;
                btb_target   = w_head_target;
            end else if (r_state == ST_FLUSH) begin
                btb_write_en = 1'b1;
                btb_index    = r_sweep_idx;
            end
        end
    end

    assign flush_busy = (r_state == ST_FLUSH);
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btb_update_ctrl
//  Description : Scoreboard bench for btb_update_ctrl with a queue-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_update_ctrl;

    localparam int DEPTH = 4;
    localparam int SWEEP = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_is_jump = 1'b0;
    logic [31:0] id_pc = '0, id_target = '0;
    logic        cmt_valid = 1'b0, cmt_invalidate = 1'b0, cmt_is_jump = 1'b0;
    logic [31:0] cmt_pc = '0, cmt_target = '0;
    logic        flush_req = 1'b0;
    logic        cmt_ready, flush_busy, btb_write_en, btb_valid, btb_is_jump;
    logic [5:0]  btb_index;
    logic [31:0] btb_pc, btb_target;
    logic [15:0] drop_count;

    btb_update_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_is_jump(id_is_jump), .id_pc(id_pc), .id_target(id_target),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_invalidate(cmt_invalidate),
        .cmt_is_jump(cmt_is_jump), .cmt_pc(cmt_pc), .cmt_target(cmt_target),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .btb_write_en(btb_write_en), .btb_index(btb_index), .btb_valid(btb_valid),
        .btb_is_jump(btb_is_jump), .btb_pc(btb_pc), .btb_target(btb_target),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          v;
        bit          j;
        logic [31:0] pc;
        logic [31:0] tgt;
    } wr_t;

    wr_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  m_occ = 0;
    int  m_sweep = 0;
    int  m_drop = 0;
    bit  exp_ready, exp_busy;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [31:0] pc, input logic [31:0] tgt, input bit v, input bit j);
        wr_t w;
        w.idx = int'((pc / 32'd4) % 32'(SWEEP));
        w.v = v;  w.j = j;  w.pc = pc;  w.tgt = tgt;
        return w;
    endfunction

    function automatic wr_t mk_sweep(input int i);
        wr_t w;
        w.idx = i;  w.v = 1'b0;  w.j = 1'b0;  w.pc = '0;  w.tgt = '0;
        return w;
    endfunction

    // Monitor: every BTB write must match the oldest expected write.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst && btb_write_en) begin
                if (sb.size() == 0) begin
                    check("extra_write", 80'(btb_write_en), 80'(0));
                end else begin
                    e = sb.pop_front();
                    check("write", {btb_index, btb_valid, btb_is_jump, btb_pc, btb_target},
                          {6'(e.idx), e.v, e.j, e.pc, e.tgt});
                end
            end
        end
    end

    task automatic cycle(input bit cv, input bit ci, input bit cj, input logic [31:0] cpc,
                         input logic [31:0] ctgt, input bit iv, input bit ij,
                         input logic [31:0] ipc, input logic [31:0] itgt, input bit fl);
        int free;
        bit cacc, iacc, open;
        @(posedge clk); #1;
        cmt_valid = cv;  cmt_invalidate = ci;  cmt_is_jump = cj;  cmt_pc = cpc;  cmt_target = ctgt;
        id_valid = iv;   id_is_jump = ij;      id_pc = ipc;       id_target = itgt;
        flush_req = fl;
        cacc = 1'b0;  iacc = 1'b0;  open = 1'b0;
        if (fl) begin
            exp_ready = 1'b0;
            exp_busy  = (m_sweep > 0);
            repeat (m_occ + m_sweep) void'(sb.pop_back());
            for (int i = 0; i < SWEEP; i++) sb.push_back(mk_sweep(i));
            m_occ = 0;
            m_sweep = SWEEP;
        end else if (m_sweep > 0) begin
            exp_ready = 1'b0;
            exp_busy  = 1'b1;
            m_sweep--;
        end else begin
            open = 1'b1;
            exp_busy = 1'b0;
            free = DEPTH - m_occ + ((m_occ > 0) ? 1 : 0);
            exp_ready = (free >= 1);
            cacc = cv && exp_ready;
            iacc = iv && (free > (cacc ? 1 : 0));
            if (cacc) sb.push_back(mk(cpc, ctgt, !ci, cj));
            if (iacc) sb.push_back(mk(ipc, itgt, 1'b1, ij));
            m_occ = m_occ - ((m_occ > 0) ? 1 : 0) + int'(cacc) + int'(iacc);
        end
        @(negedge clk);
        check("cmt_ready", 80'(cmt_ready), 80'(exp_ready));
        check("flush_busy", 80'(flush_busy), 80'(exp_busy));
        check("drop_count", 80'(drop_count), 80'(m_drop));
        if (open && iv && !iacc && m_drop < 65535) m_drop++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cmt_valid = 1'b0;  id_valid = 1'b0;  flush_req = 1'b0;
        sb.delete();
        m_occ = 0;  m_sweep = 0;  m_drop = 0;
        @(negedge clk);
        check("rst_write_en", 80'(btb_write_en), 80'(0));
        check("rst_flush_busy", 80'(flush_busy), 80'(0));
        check("rst_drop_count", 80'(drop_count), 80'(0));
        check("rst_cmt_ready", 80'(cmt_ready), 80'(0));
        check("rst_index", 80'(btb_index), 80'(0));
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin : stimulus
        do_reset();

        // Single ID update lands on line 2 the next cycle.
        cycle(0, 0, 0, '0, '0, 1, 0, 32'h0000_1008, 32'h0000_2000, 0);
        idle(3);

        // Commit invalidate and ID in the same cycle, both on line 0.
        cycle(1, 1, 0, 32'h0000_0100, 32'h0000_5000, 1, 0, 32'h0000_0200, 32'h0000_6000, 0);
        idle(3);

        // Sustained pressure from both requesters.
        for (int k = 0; k < 8; k++)
            cycle(1, 0, k[0], 32'h0000_4000 + 32'(k * 4), 32'h0000_8000 + 32'(k * 16),
                  1, 1, 32'h0000_9000 + 32'(k * 4), 32'h0000_A000 + 32'(k * 8), 0);
        idle(6);
        check("drop_nonzero", 80'(drop_count != 16'd0), 80'(1));

        // Randomized traffic.
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  32'($urandom), 32'($urandom),
                  $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                  32'($urandom), 32'($urandom), 0);
        idle(6);

        // Three pending entries discarded by a flush; ID during the sweep is not counted.
        cycle(1, 0, 0, 32'h0000_0300, 32'h0000_1111, 1, 0, 32'h0000_0304, 32'h0000_2222, 0);
        cycle(1, 0, 1, 32'h0000_0308, 32'h0000_3333, 1, 1, 32'h0000_030C, 32'h0000_4444, 0);
        cycle(0, 0, 0, '0, '0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 70; k++)
            cycle($urandom_range(0, 1) == 1, 0, 0, 32'($urandom), 32'($urandom),
                  $urandom_range(0, 1) == 1, 0, 32'($urandom), 32'($urandom), 0);
        idle(6);

        // Flush restarted at sweep index 30.
        cycle(0, 0, 0, '0, '0, 0, 0, '0, '0, 1);
        idle(30);
        cycle(0, 0, 0, '0, '0, 0, 0, '0, '0, 1);
        idle(70);

        // Reset in the middle of a sweep, then a normal update.
        cycle(0, 0, 0, '0, '0, 0, 0, '0, '0, 1);
        idle(10);
        do_reset();
        cycle(0, 0, 0, '0, '0, 1, 1, 32'h0000_0044, 32'h0000_7000, 0);
        idle(4);

        check("sb_empty", 80'(sb.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Sequences all writes into the branch target buffer's single write port. Two requesters feed it: ID (newly decoded branch/jump, best-effort hint) and commit (resolved-branch correction or entry invalidation, must not be lost). Requests are buffered in a small queue and drained one BTB write per cycle. A flush FSM sweeps every line to invalid on context change.

Parameters:
ADDR_WIDTH, 32, width of PC/target fields (matches ADDR_BUS)
BTB_SIZE, 64, number of BTB lines; power of two
INDEX_WIDTH, 6, log2(BTB_SIZE); line index = pc[INDEX_WIDTH+1:2]
QUEUE_DEPTH, 4, update-queue entries; power of two, >=2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID presents a branch/jump update
id_is_jump  in  1  ID entry is unconditional jump
id_pc  in  ADDR_WIDTH  PC of ID instruction
id_target  in  ADDR_WIDTH  ID target
cmt_valid  in  1  commit presents an update
cmt_ready  out  1  commit update accepted this cycle
cmt_invalidate  in  1  commit update clears the line (valid=0)
cmt_is_jump  in  1  commit entry is jump
cmt_pc  in  ADDR_WIDTH  PC of committed branch
cmt_target  in  ADDR_WIDTH  resolved target
flush_req  in  1  one-cycle pulse: invalidate whole BTB
flush_busy  out  1  flush sweep in progress
btb_write_en  out  1  write strobe to BTB
btb_index  out  INDEX_WIDTH  line to write
btb_valid  out  1  valid bit written
btb_is_jump  out  1  jump bit written
btb_pc  out  ADDR_WIDTH  PC written (BTB keeps its tag bits)
btb_target  out  ADDR_WIDTH  target written
drop_count  out  16  saturating count of dropped ID updates

Behaviour:
- Reset (rst=0, async): queue empty, state IDLE, all outputs 0, drop_count 0; cmt_ready rises in first cycle after release.
- States: IDLE (queue empty), DRAIN (queue non-empty), FLUSH. IDLE<->DRAIN by queue occupancy; any state -> FLUSH on flush_req; FLUSH -> IDLE after last index.
- Enqueue (IDLE/DRAIN): cmt_ready = free slots >=1 (counting this cycle's dequeue). Commit has priority: accepted commit enqueued first, then ID if a slot remains; both in one cycle when >=2 free. ID never stalls: ID not enqueued while id_valid=1 -> drop_count +1 (saturate at 0xFFFF).
- Entry stored: valid=~invalidate (ID always 1), is_jump, pc, target, index from pc.
- Dequeue: one entry per cycle from head; outputs registered; entry enqueued in cycle N appears on btb_* with btb_write_en=1 in cycle N+1 at the earliest. FIFO order strictly preserved; no merging of same-index entries.
- Simultaneous enqueue+dequeue at full: dequeue slot counts as free in same cycle.
- Pointers wrap modulo QUEUE_DEPTH; occupancy counter 0..QUEUE_DEPTH.
- FLUSH: on flush_req queue discarded (pending entries lost, no write that cycle); counter from 0; each cycle btb_write_en=1, btb_valid=0, btb_index=counter, other fields 0; BTB_SIZE cycles total. flush_busy=1 from cycle after flush_req through last sweep write. cmt_ready=0 during FLUSH; id_valid during FLUSH dropped but NOT counted.
- flush_req during FLUSH restarts counter at 0.
- Reset mid-sweep or mid-drain: immediate return to reset state; no further writes.

Decomposition:
- Shared branch header: BTB_SIZE, INDEX_WIDTH, index-select macro, QUEUE_DEPTH default, FSM state encodings (IDLE/DRAIN/FLUSH).
- One sub-module: btb_update_fifo (2-write/1-read queue with occupancy and free-slot output); FSM, arbitration and flush counter live in top.

Test Plan:
- Single ID update pc=0x0000_1008, target=0x0000_2000, jump=0 -> next cycle write_en=1, index=2, valid=1, target=0x2000; queue empty after.
- ID and commit same cycle (cmt_pc=0x100, invalidate=1; id_pc=0x200) -> writes in order index 0 (valid=0) then index 0 for 0x200 (valid=1), consecutive cycles.
- Hold cmt_valid and id_valid 8 cycles, distinct PCs -> cmt_ready never low when slot free, all 8 commits written in order, drop_count equals lost ID updates (nonzero), no commit lost.
- Fill queue with 3 entries, pulse flush_req -> pending entries never written, 64 writes valid=0 index 0..63, flush_busy high exactly 64 cycles, cmt_ready=0 throughout.
- flush_req again at sweep index 30 -> index restarts at 0, total sweep 30+64 writes, then IDLE.
- Assert rst low mid-sweep at index 10 -> btb_write_en 0 immediately, flush_busy 0, drop_count 0; ID update after release written normally.
